// File: rtl/cpu_run_controller.sv
// cpu_run_controller
//   Run-control sequencer for the 64-bit single-cycle ARM CPU. After a start
//   request it holds the CPU in reset for RESET_CYCLES cycles, then lets it
//   run. It counts run cycles and ends the run on either a halt or a timeout.
//   A halt is a branch-to-self, seen as the PC repeating HALT_REPEAT times.
//   A timeout means the MAX_CYCLES budget is used up; 0 means unlimited.
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        synchronous active-high reset (overrides start/abort)
//   start        begin a run (honoured in IDLE and DONE only)
//   abort        end the current run and return to IDLE
//   pc           observed CPU program counter
//   pc_valid     pc is meaningful this cycle
//   cpu_reset    reset to CPU_64bit (high everywhere except RUN)
//   running      high in RUN
//   done         high in DONE
//   halted       run ended by halt detect (sticky until next start)
//   timeout      run ended by budget expiry (sticky until next start)
//   cycle_count  RUN cycles completed, saturating
module cpu_run_controller #(
    parameter int PC_WIDTH     = 64,
    parameter int CNT_WIDTH    = 32,
    parameter int RESET_CYCLES = 1,
    parameter int MAX_CYCLES   = 34,
    parameter int HALT_REPEAT  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 pc_valid,
    output logic                 cpu_reset,
    output logic                 running,
    output logic                 done,
    output logic                 halted,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RSTHOLD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [31:0]        RST_LAST = 32'(RESET_CYCLES - 1);
    localparam logic [31:0]        HALT_N   = 32'(HALT_REPEAT);
    localparam logic [CNT_WIDTH:0] MAX_N    = (CNT_WIDTH + 1)'(MAX_CYCLES);

    state_t                 state;
    logic [31:0]            rst_cnt;
    logic [31:0]            rep_cnt;
    logic [PC_WIDTH-1:0]    prev_pc;
    logic                   have_prev;
    logic                   halted_q;
    logic                   timeout_q;
    logic [CNT_WIDTH-1:0]   cycle_q;

    logic                   match;
    logic [31:0]            rep_next;
    logic                   halt_hit;
    logic                   to_hit;
    logic [CNT_WIDTH:0]     cnt_inc;
    logic [CNT_WIDTH-1:0]   cycle_next;

    always_comb begin
        match      = have_prev && (pc == prev_pc);
        rep_next   = rep_cnt + 32'd1;
        halt_hit   = pc_valid && match && (rep_next == HALT_N);
        // compared one bit wider so the budget test never wraps
        cnt_inc    = {1'b0, cycle_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
        to_hit     = (MAX_CYCLES != 0) && (cnt_inc == MAX_N);
        cycle_next = (&cycle_q) ? cycle_q : cnt_inc[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rst_cnt   <= '0;
            rep_cnt   <= '0;
            prev_pc   <= '0;
            have_prev <= 1'b0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            cycle_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RSTHOLD;
                        rst_cnt   <= '0;
                        rep_cnt   <= '0;
                        prev_pc   <= '0;
                        have_prev <= 1'b0;
                        halted_q  <= 1'b0;
                        timeout_q <= 1'b0;
                        cycle_q   <= '0;
                    end
                end
                S_RSTHOLD: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (rst_cnt == RST_LAST) begin
                        state <= S_RUN;
                    end else begin
                        rst_cnt <= rst_cnt + 32'd1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        // abort beats both end events and freezes the count
                        state <= S_IDLE;
                    end else begin
                        cycle_q <= cycle_next;
                        if (pc_valid) begin
                            rep_cnt   <= match ? rep_next : '0;
                            prev_pc   <= pc;
                            have_prev <= 1'b1;
                        end
                        // halt takes precedence when both land on one edge
                        if (halt_hit) begin
                            state    <= S_DONE;
                            halted_q <= 1'b1;
                        end else if (to_hit) begin
                            state     <= S_DONE;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (start) begin
                        state     <= S_RSTHOLD;
                        rst_cnt   <= '0;
                        rep_cnt   <= '0;
                        prev_pc   <= '0;
                        have_prev <= 1'b0;
                        halted_q  <= 1'b0;
                        timeout_q <= 1'b0;
                        cycle_q   <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // all outputs are decoded from registered state and flags only
    assign cpu_reset   = (state != S_RUN);
    assign running     = (state == S_RUN);
    assign done        = (state == S_DONE);
    assign halted      = halted_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
module tb_cpu_run_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [63:0] pc = '0;
    logic        pc_valid = 1'b0;

    // instance a: defaults
    logic        a_cpu_reset, a_running, a_done, a_halted, a_timeout;
    logic [31:0] a_count;
    // instance b: MAX_CYCLES=5
    logic        b_cpu_reset, b_running, b_done, b_halted, b_timeout;
    logic [31:0] b_count;
    // instance c: RESET_CYCLES=3
    logic        c_cpu_reset, c_running, c_done, c_halted, c_timeout;
    logic [31:0] c_count;

    int unsigned total = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    cpu_run_controller dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pc(pc), .pc_valid(pc_valid),
        .cpu_reset(a_cpu_reset), .running(a_running), .done(a_done),
        .halted(a_halted), .timeout(a_timeout), .cycle_count(a_count)
    );

    cpu_run_controller #(.MAX_CYCLES(5)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pc(pc), .pc_valid(pc_valid),
        .cpu_reset(b_cpu_reset), .running(b_running), .done(b_done),
        .halted(b_halted), .timeout(b_timeout), .cycle_count(b_count)
    );

    cpu_run_controller #(.RESET_CYCLES(3)) dut_c (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pc(pc), .pc_valid(pc_valid),
        .cpu_reset(c_cpu_reset), .running(c_running), .done(c_done),
        .halted(c_halted), .timeout(c_timeout), .cycle_count(c_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // ---------------- reset state
        do_reset();
        check("rst_cpu_reset", 64'(a_cpu_reset), 64'd1);
        check("rst_running",   64'(a_running),   64'd0);
        check("rst_done",      64'(a_done),      64'd0);
        check("rst_halted",    64'(a_halted),    64'd0);
        check("rst_timeout",   64'(a_timeout),   64'd0);
        check("rst_count",     64'(a_count),     64'd0);

        // ---------------- 1: timeout with stepping pc
        pc = 64'h0; pc_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_hold_1edge", 64'(a_cpu_reset), 64'd1);
        tick();
        check("t1_release_2edges", 64'(a_cpu_reset), 64'd0);
        check("t1_running", 64'(a_running), 64'd1);
        for (int unsigned i = 0; i < 33; i++) begin
            tick();
            pc = pc + 64'd4;
        end
        check("t1_count_33", 64'(a_count), 64'd33);
        check("t1_not_done_33", 64'(a_done), 64'd0);
        tick();
        check("t1_done", 64'(a_done), 64'd1);
        check("t1_timeout", 64'(a_timeout), 64'd1);
        check("t1_halted", 64'(a_halted), 64'd0);
        check("t1_count_34", 64'(a_count), 64'd34);
        check("t1_cpu_reset", 64'(a_cpu_reset), 64'd1);
        check("t1_running_off", 64'(a_running), 64'd0);
        tick();
        tick();
        check("t1_count_frozen", 64'(a_count), 64'd34);
        check("t1_done_sticky", 64'(a_done), 64'd1);

        // ---------------- 2: halt on branch-to-self at 0x20
        do_reset();
        pc = 64'h0; pc_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int unsigned i = 0; i < 9; i++) begin
            pc = 64'(i * 4);
            tick();
        end
        pc = 64'h20;
        tick();
        check("t2_first_repeat_run", 64'(a_running), 64'd1);
        check("t2_count_10", 64'(a_count), 64'd10);
        tick();
        check("t2_halted", 64'(a_halted), 64'd1);
        check("t2_timeout", 64'(a_timeout), 64'd0);
        check("t2_done", 64'(a_done), 64'd1);
        check("t2_count_11", 64'(a_count), 64'd11);
        tick();
        tick();
        check("t2_count_frozen", 64'(a_count), 64'd11);

        // ---------------- 3: halt and timeout on the same edge (MAX=5)
        do_reset();
        pc = 64'h0; pc_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        pc = 64'h0; tick();
        pc = 64'h4; tick();
        pc = 64'h8; tick();
        pc = 64'h8; tick();
        check("t3_running_4", 64'(b_running), 64'd1);
        pc = 64'h8; tick();
        check("t3_halted", 64'(b_halted), 64'd1);
        check("t3_timeout", 64'(b_timeout), 64'd0);
        check("t3_done", 64'(b_done), 64'd1);
        check("t3_count_5", 64'(b_count), 64'd5);

        // ---------------- 4: reset mid-run beats start
        do_reset();
        pc = 64'h100; pc_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int unsigned i = 0; i < 3; i++) begin
            pc = pc + 64'd4;
            tick();
        end
        check("t4_count_3", 64'(a_count), 64'd3);
        reset = 1'b1; start = 1'b1;
        tick();
        check("t4_cpu_reset", 64'(a_cpu_reset), 64'd1);
        check("t4_running", 64'(a_running), 64'd0);
        check("t4_count", 64'(a_count), 64'd0);
        check("t4_flags", 64'({a_done, a_halted, a_timeout}), 64'd0);
        reset = 1'b0; start = 1'b0;

        // ---------------- 5: abort at count 7, then restart clears count
        do_reset();
        pc = 64'h200; pc_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int unsigned i = 0; i < 7; i++) begin
            pc = pc + 64'd4;
            tick();
        end
        check("t5_count_7", 64'(a_count), 64'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_idle_cpu_reset", 64'(a_cpu_reset), 64'd1);
        check("t5_idle_running", 64'(a_running), 64'd0);
        check("t5_count_frozen", 64'(a_count), 64'd7);
        check("t5_flags", 64'({a_done, a_halted, a_timeout}), 64'd0);
        tick();
        check("t5_idle_hold", 64'(a_count), 64'd7);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_restart_count", 64'(a_count), 64'd0);

        // ---------------- 6: restart from DONE with RESET_CYCLES=3, no pc_valid
        do_reset();
        pc = 64'h300; pc_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t6a_hold_3", 64'(c_cpu_reset), 64'd1);
        tick();
        check("t6a_release_4", 64'(c_cpu_reset), 64'd0);
        for (int unsigned i = 0; i < 34; i++) tick();
        check("t6a_timeout", 64'(c_timeout), 64'd1);
        check("t6a_done", 64'(c_done), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_restart_count", 64'(c_count), 64'd0);
        check("t6_restart_timeout", 64'(c_timeout), 64'd0);
        check("t6_rst_1", 64'(c_cpu_reset), 64'd1);
        tick();
        check("t6_rst_2", 64'(c_cpu_reset), 64'd1);
        tick();
        check("t6_rst_3", 64'(c_cpu_reset), 64'd1);
        tick();
        check("t6_release", 64'(c_cpu_reset), 64'd0);
        for (int unsigned i = 0; i < 33; i++) tick();
        check("t6_not_done_33", 64'(c_done), 64'd0);
        tick();
        check("t6_timeout", 64'(c_timeout), 64'd1);
        check("t6_halted", 64'(c_halted), 64'd0);
        check("t6_count_34", 64'(c_count), 64'd34);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
